// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus LED, free-running cycle counter with
// compare interrupt, and a 4-deep byte TX FIFO, all on one CPU data port.
module dmem_responder #(
    parameter int RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        timer_irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [31:0] LED_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0004;
    localparam logic [31:0] CMP_ADDR    = 32'hFFFF_0008;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_000C;
    localparam logic [31:0] TXD_ADDR    = 32'hFFFF_0010;

    // Byte offset within a word plays no part in decoding.
    logic        unused_bits;
    logic [31:0] word_addr;
    assign unused_bits = &{1'b0, addr[1:0]};
    assign word_addr   = {addr[31:2], 2'b00};

    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    assign ram_hit = (addr[31:AW+2] == '0);
    assign ram_idx = addr[AW+1:2];

    logic sel_led, sel_cycle, sel_cmp, sel_status, sel_txd;
    assign sel_led    = (word_addr == LED_ADDR);
    assign sel_cycle  = (word_addr == CYCLE_ADDR);
    assign sel_cmp    = (word_addr == CMP_ADDR);
    assign sel_status = (word_addr == STATUS_ADDR);
    assign sel_txd    = (word_addr == TXD_ADDR);

    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (we && ram_hit) begin
            mem[ram_idx] <= wdata;
        end
    end

    logic [15:0] led_q;
    logic [31:0] cycle_q;
    logic [31:0] cmp_q;
    logic        irq_q;
    logic        ovf_q;
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic full, empty, push, pop, push_ok, ovf_set, ovf_clr, irq_set, irq_clr;
    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign push    = we && sel_txd;
    assign pop     = !empty && tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    assign ovf_clr = we && sel_status && wdata[6];
    assign irq_set = (cycle_q == cmp_q) && (cmp_q != 32'd0);
    assign irq_clr = we && sel_status && wdata[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            cycle_q <= '0;
            cmp_q   <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (we && sel_led) begin
                led_q <= wdata[15:0];
            end
            if (we && sel_cmp) begin
                cmp_q <= wdata;
            end
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = mem[ram_idx];
        end else if (sel_led) begin
            rdata = {16'h0000, led_q};
        end else if (sel_cycle) begin
            rdata = cycle_q;
        end else if (sel_cmp) begin
            rdata = cmp_q;
        end else if (sel_status) begin
            rdata = {25'd0, ovf_q, count, empty, full, irq_q};
        end
    end

    assign led       = led_q;
    assign timer_irq = irq_q;
    assign tx_valid  = !empty;
    assign tx_data   = fifo_mem[rd_ptr];

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter RAM_WORDS, default 1024, SHALL set the RAM depth in 32-bit words (power of two).
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port addr, input, 32 bits: byte address from the CPU data port; addr[1:0] is ignored.
REQ-006 Port wdata, input, 32 bits: write data from the CPU.
REQ-007 Port we, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-008 Port rdata, output, 32 bits: read data to the CPU, combinational from addr.
REQ-009 Port led, output, 16 bits: LED register contents.
REQ-010 Port timer_irq, output, 1 bit: timer interrupt pending flag.
REQ-011 Port tx_data, output, 8 bits: byte at the head of the TX FIFO.
REQ-012 Port tx_valid, output, 1 bit: TX FIFO is not empty.
REQ-013 Port tx_ready, input, 1 bit: downstream consumer accepts tx_data.

Function
REQ-014 Address map SHALL be:
- RAM: 0x0000_0000 up to RAM_WORDS*4-1, read/write.
- LED: 0xFFFF_0000, read/write, bits [15:0].
- CYCLE: 0xFFFF_0004, read-only.
- CMP: 0xFFFF_0008, read/write.
- STATUS: 0xFFFF_000C.
- TXD: 0xFFFF_0010, write-only; reads return 0.
REQ-015 Reads SHALL be combinational with zero latency: rdata reflects the register/RAM state before the next clock edge.
REQ-016 Writes SHALL take effect at the rising edge of clk when we=1.
REQ-017 Unmapped reads SHALL return 0x0000_0000; unmapped writes SHALL be ignored.
REQ-018 A RAM write SHALL store all 32 bits at word index addr[log2(RAM_WORDS)+1:2].
REQ-019 A RAM read of the same word in the cycle after a write SHALL return the new data.
REQ-020 CYCLE SHALL increment by 1 every clock, wrap from 0xFFFF_FFFF to 0, and ignore writes.
REQ-021 The irq pending flag SHALL set at the edge where CYCLE==CMP and CMP!=0; CMP==0 disables the timer.
REQ-022 Writing STATUS with wdata[0]=1 SHALL clear the irq pending flag.
REQ-023 If an irq set and a clear occur on the same edge, the set SHALL win.
REQ-024 timer_irq SHALL equal the irq pending flag.
REQ-025 STATUS read bits SHALL be:
- [0] irq pending
- [1] fifo full
- [2] fifo empty
- [5:3] fifo count (0-4)
- [6] sticky overflow
- [31:7] zero
REQ-026 Writing STATUS with wdata[6]=1 SHALL clear the sticky overflow bit.
REQ-027 The TX FIFO SHALL be 4 entries x 8 bits, built from circular pointers that wrap modulo 4.
REQ-028 A TXD write SHALL push wdata[7:0].
REQ-029 A push while full with no pop on the same edge SHALL be dropped and SHALL set overflow.
REQ-030 tx_valid SHALL be 1 exactly when count>0, and tx_data SHALL be the head entry.
REQ-031 A pop SHALL occur on an edge where tx_valid=1 and tx_ready=1.
REQ-032 Push and pop on the same edge SHALL leave count unchanged.
REQ-033 If push and pop occur on the same edge while full, the push SHALL be accepted and SHALL NOT set overflow.
REQ-034 If a push occurs while empty with tx_ready=1, no pop SHALL occur that edge, and tx_valid SHALL rise the next cycle.
REQ-035 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.

Reset
REQ-036 rst=1 SHALL immediately (asynchronously) force:
- LED=0, CYCLE=0, CMP=0
- irq=0, overflow=0
- FIFO pointers and count=0
REQ-037 As a result of REQ-036, during reset led=0, timer_irq=0 and tx_valid=0.
REQ-038 RAM contents SHALL NOT be reset.
REQ-039 A reset asserted mid-FIFO-drain SHALL discard all queued bytes.
REQ-040 After rst deasserts, CYCLE SHALL read 0 in the first cycle and 1 after the first clock edge.

Verification
REQ-041 RAM check: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF; a read of 0x0000_1000 with RAM_WORDS=1024 -> 0.
REQ-042 LED check: write 0x1234_ABCD to 0xFFFF_0000 -> led=0xABCD, and a readback returns 0x0000_ABCD.
REQ-043 Timer check: write CMP=20 -> timer_irq rises after the edge where CYCLE==20; write STATUS=0x1 -> timer_irq falls; CMP=0 -> timer_irq never asserts across a wrap.
REQ-044 FIFO fill check: with tx_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 -> STATUS=0x62 (full, count 4, overflow); then tx_ready=1 -> output bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, after which tx_valid=0.
REQ-045 Simultaneous push/pop check: with the FIFO full and tx_ready=1, push 0x66 -> count stays 4, overflow stays 0, and 0x66 is output last.
REQ-046 Reset check: assert rst with 3 bytes queued and irq pending -> tx_valid=0, timer_irq=0 and led=0 immediately, without waiting for a clock edge.
